// File: rtl/enc_secded_stream.sv
// SECDED (extended Hamming) stream encoder, 8/16/32-bit codewords per beat.
// Valid/ready input, registered output FIFO, error injection, word counter.
module enc_secded_stream #(
    parameter int AMBA_WORD  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AMBA_WORD-1:0] data_in,
    input  logic [1:0]           codeword_width,
    input  logic [AMBA_WORD-1:0] err_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AMBA_WORD-1:0] enc_out,
    output logic [1:0]           out_width,
    output logic                 err_illegal,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] W_S   = 2'b00;
    localparam logic [1:0] W_M   = 2'b01;
    localparam logic [1:0] W_L   = 2'b10;
    localparam logic [1:0] W_ILL = 2'b11;

    // Column values walk 3,5,6,7,9,... skipping powers of two; d0 is the
    // field MSB, so the data is left-aligned and shifted out from the top.
    function automatic logic [31:0] secded(input logic [25:0] d,
                                           input int k, input int p);
        logic [25:0] sh;
        logic [5:0]  par;
        logic [31:0] pf;
        logic        di;
        logic        ov;
        int          c;
        sh  = d << (26 - k);
        par = '0;
        ov  = 1'b0;
        c   = 2;
        for (int i = 0; i < 26; i++) begin
            if (i < k) begin
                c = c + 1;
                if ((c & (c - 1)) == 0) c = c + 1;
                di = sh[25];
                sh = sh << 1;
                ov = ov ^ di;
                for (int j = 0; j < 5; j++) begin
                    if (c[j]) par[j] = par[j] ^ di;
                end
            end
        end
        ov = ov ^ (^par);
        pf = '0;
        for (int j = 0; j < 5; j++) begin
            if (j < p - 1) pf = {pf[30:0], par[j]};
        end
        pf = {pf[30:0], ov};
        return ((32'(d) & ((32'd1 << k) - 32'd1)) << p) | pf;
    endfunction

    logic [31:0] cw_s, cw_m, cw_l;
    logic [31:0] cw, wmask;
    logic [AMBA_WORD-1:0] stored;

    assign cw_s = secded(data_in[25:0], 4, 4);
    assign cw_m = secded(data_in[25:0], 11, 5);
    assign cw_l = secded(data_in[25:0], 26, 6);

    always_comb begin
        cw    = '0;
        wmask = '0;
        unique case (1'b1)
            (codeword_width == W_S): begin
                cw    = cw_s;
                wmask = 32'h0000_00FF;
            end
            (codeword_width == W_M): begin
                cw    = cw_m;
                wmask = 32'h0000_FFFF;
            end
            (codeword_width == W_L): begin
                cw    = cw_l;
                wmask = 32'hFFFF_FFFF;
            end
            default: ;
        endcase
    end

    assign stored = AMBA_WORD'(cw ^ (err_mask[31:0] & wmask));

    logic [AMBA_WORD-1:0] mem_d [FIFO_DEPTH];
    logic [1:0]           mem_w [FIFO_DEPTH];
    logic [PW-1:0]        wptr, rptr;
    logic [PW:0]          count;
    logic                 fire, legal, push, pop;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign fire      = in_valid && in_ready;
    assign legal     = (codeword_width != W_ILL);
    assign push      = fire && legal;
    assign pop       = out_valid && out_ready;

    assign enc_out   = out_valid ? mem_d[rptr] : '0;
    assign out_width = out_valid ? mem_w[rptr] : 2'b00;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wptr] <= stored;
            mem_w[wptr] <= codeword_width;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
            word_cnt    <= '0;
        end else begin
            err_illegal <= fire && !legal;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && !(&word_cnt)) word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_enc_secded_stream.sv
// Bench for enc_secded_stream: directed steps plus random beats,
// checked against a queue-based reference built from the column rule.
module tb_enc_secded_stream;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  codeword_width;
    logic [31:0] err_mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] enc_out;
    logic [1:0]  out_width;
    logic        err_illegal;
    logic [15:0] word_cnt;

    enc_secded_stream #(
        .AMBA_WORD (32),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .codeword_width(codeword_width),
        .err_mask      (err_mask),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .enc_out       (enc_out),
        .out_width     (out_width),
        .err_illegal   (err_illegal),
        .word_cnt      (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [1:0]  t;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    cnt   = 0;
    int    npop  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input logic [1:0] w,
                                            input logic [31:0] d,
                                            input logic [31:0] m);
        int     k, p, c, par, ones;
        int     cols[$];
        longint field, cw;
        case (w)
            2'b00:   begin k = 4;  p = 4; end
            2'b01:   begin k = 11; p = 5; end
            default: begin k = 26; p = 6; end
        endcase
        c = 3;
        while (cols.size() < k) begin
            if ((c & (c - 1)) != 0) cols.push_back(c);
            c++;
        end
        field = longint'(d) & ((longint'(1) << k) - 1);
        cw    = field << p;
        ones  = 0;
        for (int i = 0; i < k; i++)
            ones += int'((field >> (k - 1 - i)) & 1);
        for (int j = 0; j < p - 1; j++) begin
            par = 0;
            for (int i = 0; i < k; i++)
                if (((cols[i] >> j) & 1) == 1)
                    par ^= int'((field >> (k - 1 - i)) & 1);
            ones += par;
            cw += longint'(par) << (p - 1 - j);
        end
        cw += ones % 2;
        cw ^= longint'(m) & ((longint'(1) << (k + p)) - 1);
        return cw[31:0];
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic v, input logic [1:0] w,
                         input logic [31:0] d, input logic [31:0] m,
                         input logic ordy);
        logic  fire, popx, ill;
        item_t it;
        in_valid       = v;
        codeword_width = w;
        data_in        = d;
        err_mask       = m;
        out_ready      = ordy;
        #1;
        fire = v && in_ready;
        popx = out_valid && ordy;
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("out_valid", out_valid, q.size() != 0);
        if (popx && q.size() != 0) begin
            chk("enc_out", enc_out, q[0].w);
            chk("out_width", out_width, q[0].t);
            void'(q.pop_front());
            npop++;
        end
        ill = fire && (w == 2'b11);
        if (fire && w != 2'b11) begin
            it.w = ref_enc(w, d, m);
            it.t = w;
            q.push_back(it);
            if (cnt != 16'hFFFF) cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        chk("err_illegal", err_illegal, ill);
        chk("word_cnt", word_cnt, cnt);
    endtask

    int          c0, p0;
    logic [1:0]  rw;
    logic [31:0] kk;

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        codeword_width = 2'b00;
        data_in        = '0;
        err_mask       = '0;
        out_ready      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_enc_out", enc_out, 0);
        chk("rst_out_width", out_width, 0);
        chk("rst_err_illegal", err_illegal, 0);
        chk("rst_word_cnt", word_cnt, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Small 0xB, then with upper mask bits that must be suppressed
        cycle(1'b1, 2'b00, 32'h0000_000B, 32'h0, 1'b0);
        chk("small_b4", enc_out, 32'h0000_00B4);
        chk("small_valid", out_valid, 1);
        chk("small_width", out_width, 2'b00);
        chk("small_cnt", word_cnt, 1);
        cycle(1'b1, 2'b00, 32'h0000_000B, 32'hFFFF_FF01, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        chk("small_b5", enc_out, 32'h0000_00B5);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

        // All-ones and walking-one data for each width
        for (int w = 0; w < 3; w++) begin
            kk = (w == 0) ? 4 : (w == 1) ? 11 : 26;
            cycle(1'b1, 2'(w), 32'hFFFF_FFFF, 32'h0, 1'b1);
            for (int i = 0; i < int'(kk); i++)
                cycle(1'b1, 2'(w), 32'd1 << i, 32'h0, 1'b1);
        end
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

        // Fill with out_ready low, then drain and overlap at full
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b1, 2'($urandom_range(0, 2)), $urandom, 32'h0, 1'b0);
        chk("full_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("drained", out_valid, 0);

        // Illegal beat sandwiched between two legal ones
        c0 = cnt;
        p0 = npop;
        cycle(1'b1, 2'b01, $urandom, 32'h0, 1'b1);
        cycle(1'b1, 2'b11, $urandom, 32'h0, 1'b1);
        chk("ill_pulse", err_illegal, 1);
        cycle(1'b1, 2'b10, $urandom, 32'h0, 1'b1);
        chk("ill_gone", err_illegal, 0);
        repeat (3) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("ill_npop", npop - p0, 2);
        chk("ill_cnt", word_cnt, c0 + 2);

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            rw = 2'($urandom_range(0, 3));
            cycle(1'($urandom), rw, $urandom,
                  ($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
                  1'($urandom));
        end

        // Asynchronous reset with the FIFO half full
        repeat (8) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        cycle(1'b1, 2'b01, $urandom, 32'h0, 1'b0);
        cycle(1'b1, 2'b10, $urandom, 32'h0, 1'b0);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_enc_out", enc_out, 0);
        chk("arst_out_width", out_width, 0);
        chk("arst_err_illegal", err_illegal, 0);
        chk("arst_word_cnt", word_cnt, 0);
        q.delete();
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        cycle(1'b1, 2'b00, 32'h0000_000B, 32'h0, 1'b0);
        chk("restart_b4", enc_out, 32'h0000_00B4);
        chk("restart_cnt", word_cnt, 1);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

        // Run the counter past all-ones
        for (int i = 0; i < 65540; i++)
            cycle(1'b1, 2'($urandom_range(0, 2)), $urandom, 32'h0, 1'b1);
        chk("sat_cnt", word_cnt, 16'hFFFF);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
